// File: rtl/c880_bist_pkg.sv
// rtl/c880_bist_pkg.sv - shared types and constants for the c880 BIST controller
// Purpose: FSM state encoding, LFSR/MISR/counter widths, MISR feedback polynomial
//          and the LFSR step function used by the top level.
// Optional feature macro: C880_BIST_PIPE_EN (DRAIN state is only entered when defined).
package c880_bist_pkg;

  localparam int LFSR_W = 60;
  localparam int MISR_W = 26;
  localparam int CNT_W  = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 26'h47;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Fibonacci LFSR step: shift left, feedback from the two top taps.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[LFSR_W-2]};
  endfunction

endpackage

// File: rtl/c880_bist_misr.sv
// rtl/c880_bist_misr.sv - 26-bit multiple-input signature register
// Purpose: compacts one response word per enabled cycle into the signature.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset (signature -> 0)
//   clr  in   synchronous clear, wins over en
//   en   in   compact resp this cycle
//   resp in   [25:0] response word
//   sig  out  [25:0] current signature
module c880_bist_misr
  import c880_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [MISR_W-1:0] resp,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0) ^ resp;
    end
  end

endmodule

// File: rtl/c880_bist.sv
// rtl/c880_bist.sv - LFSR/MISR built-in self test controller for the c880 netlist
// Purpose: on start, applies PATTERN_CNT pseudo-random 60-bit patterns to the c880
//          inputs and compacts its 26-bit responses into a signature, then reports
//          done and pass (signature equals golden_sig).
// Optional feature macro: C880_BIST_PIPE_EN - registers response_i one stage before
//          the MISR and adds a one-cycle DRAIN state to compact the final response.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   run request, honoured in IDLE or DONE
//   abort        in   terminate run, back to IDLE without done
//   golden_sig   in   [25:0] expected signature
//   pattern_o    out  [59:0] stimulus, bit 59 = N1
//   response_i   in   [25:0] c880 outputs, bit 25 = N388
//   busy         out  high in RUN/DRAIN
//   done         out  high in DONE
//   pass         out  done and signature matches golden_sig
//   signature_o  out  [25:0] MISR contents
module c880_bist
  import c880_bist_pkg::*;
#(
  parameter logic [CNT_W-1:0]  PATTERN_CNT = 16'd1023,
  parameter logic [LFSR_W-1:0] SEED        = 60'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [MISR_W-1:0] golden_sig,
  output logic [LFSR_W-1:0] pattern_o,
  input  logic [MISR_W-1:0] response_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature_o
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 60'h1 : SEED;
  localparam logic [CNT_W-1:0]  LAST_CNT = PATTERN_CNT - CNT_W'(1);
  localparam logic              ZERO_RUN = (PATTERN_CNT == '0);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [LFSR_W-1:0]  lfsr;
  logic               start_ok;
  logic               last_pat;
  logic               misr_en;
  logic [MISR_W-1:0]  misr_in;
  logic [MISR_W-1:0]  sig;

  assign start_ok = start && !abort && (state == ST_IDLE || state == ST_DONE);
  assign last_pat = (state == ST_RUN) && (cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides everything else
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) state_nxt = ZERO_RUN ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
`ifdef C880_BIST_PIPE_EN
          if (last_pat) state_nxt = ST_DRAIN;
`else
          if (last_pat) state_nxt = ST_DONE;
`endif
        end
        ST_DRAIN: state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
    pass = done && (sig == golden_sig);
  end

  // Pattern generator and counter. The LFSR does not step on the final RUN
  // edge so the last applied pattern stays visible in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= '0;
      cnt  <= '0;
    end else if (abort) begin
      lfsr <= '0;
      cnt  <= '0;
    end else if (start_ok) begin
      lfsr <= ZERO_RUN ? '0 : SEED_EFF;
      cnt  <= '0;
    end else if (state == ST_RUN && !last_pat) begin
      lfsr <= lfsr_step(lfsr);
      cnt  <= cnt + CNT_W'(1);
    end
  end

`ifdef C880_BIST_PIPE_EN
  // Response of pattern k is compacted one cycle later; the first RUN cycle
  // only fills the register and DRAIN consumes the final response.
  logic [MISR_W-1:0] resp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q <= '0;
    end else if (state == ST_RUN) begin
      resp_q <= response_i;
    end
  end

  assign misr_in = resp_q;
  assign misr_en = !abort && ((state == ST_RUN && cnt != '0) || state == ST_DRAIN);
`else
  assign misr_in = response_i;
  assign misr_en = !abort && (state == ST_RUN);
`endif

  c880_bist_misr u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .en   (misr_en),
    .resp (misr_in),
    .sig  (sig)
  );

  assign pattern_o   = lfsr;
  assign signature_o = sig;

endmodule

// File: tb/tb_c880_bist.sv
// tb/tb_c880_bist.sv - self-checking bench for c880_bist
module tb_c880_bist;

`ifdef C880_BIST_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam logic [59:0] BIG_SEED = 60'h123456789ABCDEF;
  localparam int BIG_CNT = 1023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  logic [59:0] pat_q[$];

  // Large instance: stand-in c880 response with optional stuck-at-0 on N880 (bit 0)
  logic        big_start, big_abort, big_busy, big_done, big_pass, stuck;
  logic [25:0] big_golden, big_resp, big_sig;
  logic [59:0] big_pat;
  // Two-pattern instance, zero seed (must behave as seed 1)
  logic        sm_start, sm_abort, sm_busy, sm_done, sm_pass;
  logic [25:0] sm_golden, sm_sig;
  logic [59:0] sm_pat;
  // Zero-pattern instance
  logic        z_start, z_abort, z_busy, z_done, z_pass;
  logic [25:0] z_golden, z_sig;
  logic [59:0] z_pat;

  function automatic logic [59:0] lfsr_m(input logic [59:0] v);
    return {v[58:0], v[59] ^ v[58]};
  endfunction

  function automatic logic [25:0] misr_m(input logic [25:0] s, input logic [25:0] r);
    return {s[24:0], 1'b0} ^ (s[25] ? 26'h47 : 26'h0) ^ r;
  endfunction

  function automatic logic [25:0] resp_fn(input logic [59:0] p);
    return p[59:34] ^ p[33:8] ^ {p[7:0], p[59:42]} ^ ({26{p[5]}} & p[45:20]);
  endfunction

  assign big_resp = resp_fn(big_pat) & {{25{1'b1}}, ~stuck};

  c880_bist #(.PATTERN_CNT(16'd1023), .SEED(BIG_SEED)) u_big (
    .clk(clk), .rst(rst), .start(big_start), .abort(big_abort), .golden_sig(big_golden),
    .pattern_o(big_pat), .response_i(big_resp), .busy(big_busy), .done(big_done),
    .pass(big_pass), .signature_o(big_sig));

  c880_bist #(.PATTERN_CNT(16'd2), .SEED(60'h0)) u_small (
    .clk(clk), .rst(rst), .start(sm_start), .abort(sm_abort), .golden_sig(sm_golden),
    .pattern_o(sm_pat), .response_i(26'h1), .busy(sm_busy), .done(sm_done),
    .pass(sm_pass), .signature_o(sm_sig));

  c880_bist #(.PATTERN_CNT(16'd0), .SEED(60'h5)) u_zero (
    .clk(clk), .rst(rst), .start(z_start), .abort(z_abort), .golden_sig(z_golden),
    .pattern_o(z_pat), .response_i(26'h3FFFFFF), .busy(z_busy), .done(z_done),
    .pass(z_pass), .signature_o(z_sig));

  // Loads the expected pattern sequence of the large instance and returns the
  // fault-free signature.
  task automatic fill_big(output logic [25:0] sig);
    logic [59:0] p;
    pat_q.delete();
    p = BIG_SEED;
    sig = '0;
    for (int i = 0; i < BIG_CNT; i++) begin
      pat_q.push_back(p);
      sig = misr_m(sig, resp_fn(p));
      p = lfsr_m(p);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_checks++;
    if ({big_pat, big_sig, big_busy, big_done, big_pass} !== '0) begin
      n_fail++; $display("FAIL reset_big: got pat=%h sig=%h busy=%b done=%b pass=%b, want all 0",
                         big_pat, big_sig, big_busy, big_done, big_pass);
    end
    n_checks++;
    if ({sm_pat, sm_sig, sm_busy, sm_done, sm_pass} !== '0) begin
      n_fail++; $display("FAIL reset_small: got pat=%h sig=%h busy=%b done=%b, want all 0",
                         sm_pat, sm_sig, sm_busy, sm_done);
    end
    n_checks++;
    if ({z_pat, z_sig, z_busy, z_done, z_pass} !== '0) begin
      n_fail++; $display("FAIL reset_zero: got pat=%h sig=%h done=%b, want all 0", z_pat, z_sig, z_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count;
    z_golden = 26'h0;
    z_start = 1'b1;
    @(posedge clk); #1;
    z_start = 1'b0;
    n_checks++;
    if (z_done !== 1'b1 || z_busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done=%b busy=%b, want done=1 busy=0", z_done, z_busy);
    end
    n_checks++;
    if (z_sig !== 26'h0) begin
      n_fail++; $display("FAIL zero_sig: got %h, want 0", z_sig);
    end
    n_checks++;
    if (z_pass !== 1'b1) begin
      n_fail++; $display("FAIL zero_pass: got %b, want 1", z_pass);
    end
    z_golden = 26'h1;
    #1;
    n_checks++;
    if (z_pass !== 1'b0) begin
      n_fail++; $display("FAIL zero_pass_bad_golden: got %b, want 0", z_pass);
    end
  endtask

  task automatic test_small;
    int edges;
    logic [59:0] exp_p;
    pat_q.delete();
    pat_q.push_back(60'h1);
    pat_q.push_back(60'h2);
    sm_golden = 26'h3;
    sm_start = 1'b1;
    @(posedge clk); #1;
    sm_start = 1'b0;
    edges = 0;
    while (!sm_done && edges < 20) begin
      if (sm_busy && pat_q.size() > 0) begin
        exp_p = pat_q.pop_front();
        n_checks++;
        if (sm_pat !== exp_p) begin
          n_fail++; $display("FAIL small_pattern: got %h, want %h", sm_pat, exp_p);
        end
      end
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (edges != 2 + PIPE || pat_q.size() != 0) begin
      n_fail++; $display("FAIL small_latency: done after %0d edges (%0d patterns unseen), want %0d",
                         edges, pat_q.size(), 2 + PIPE);
    end
    n_checks++;
    if (sm_sig !== 26'h3) begin
      n_fail++; $display("FAIL small_sig: got %h, want 3", sm_sig);
    end
    n_checks++;
    if (sm_pass !== 1'b1) begin
      n_fail++; $display("FAIL small_pass: got %b, want 1", sm_pass);
    end
    n_checks++;
    if (sm_pat !== 60'h2) begin
      n_fail++; $display("FAIL small_hold_pattern: got %h, want 2", sm_pat);
    end
    sm_golden = 26'h2;
    #1;
    n_checks++;
    if (sm_pass !== 1'b0) begin
      n_fail++; $display("FAIL small_pass_bad_golden: got %b, want 0", sm_pass);
    end
    // Restart straight from DONE
    sm_start = 1'b1;
    @(posedge clk); #1;
    sm_start = 1'b0;
    n_checks++;
    if (sm_done !== 1'b0 || sm_busy !== 1'b1 || sm_pat !== 60'h1 || sm_sig !== 26'h0) begin
      n_fail++; $display("FAIL small_restart: got done=%b busy=%b pat=%h sig=%h, want 0 1 1 0",
                         sm_done, sm_busy, sm_pat, sm_sig);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_full_run;
    int edges;
    logic [25:0] good_sig, unused_sig;
    logic [59:0] exp_p;
    for (int f = 0; f < 2; f++) begin
      fill_big(good_sig);
      if (f == 0) unused_sig = good_sig;
      big_golden = unused_sig;
      stuck = (f == 1);
      big_start = 1'b1;
      @(posedge clk); #1;
      big_start = 1'b0;
      edges = 0;
      while (!big_done && edges < 3000) begin
        if (big_busy && pat_q.size() > 0) begin
          exp_p = pat_q.pop_front();
          n_checks++;
          if (big_pat !== exp_p) begin
            n_fail++; $display("FAIL full_pattern: got %h, want %h", big_pat, exp_p);
          end
        end
        @(posedge clk); #1;
        edges++;
      end
      n_checks++;
      if (edges != BIG_CNT + PIPE || pat_q.size() != 0) begin
        n_fail++; $display("FAIL full_latency: done after %0d edges (%0d patterns unseen), want %0d",
                           edges, pat_q.size(), BIG_CNT + PIPE);
      end
      if (f == 0) begin
        n_checks++;
        if (big_sig !== good_sig || big_pass !== 1'b1) begin
          n_fail++; $display("FAIL full_signature: got sig=%h pass=%b, want sig=%h pass=1",
                             big_sig, big_pass, good_sig);
        end
      end else begin
        n_checks++;
        if (big_pass !== 1'b0 || big_sig === good_sig) begin
          n_fail++; $display("FAIL stuck_at_detect: got sig=%h pass=%b, want sig!=%h pass=0",
                             big_sig, big_pass, good_sig);
        end
      end
    end
    stuck = 1'b0;
  endtask

  task automatic test_start_spam;
    int edges;
    logic [25:0] good_sig;
    fill_big(good_sig);
    big_golden = good_sig;
    big_start = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (!big_done && edges < 3000) begin
      big_start = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    big_start = 1'b0;
    n_checks++;
    if (edges != BIG_CNT + PIPE) begin
      n_fail++; $display("FAIL spam_latency: done after %0d edges, want %0d", edges, BIG_CNT + PIPE);
    end
    n_checks++;
    if (big_sig !== good_sig || big_pat !== pat_q[BIG_CNT-1]) begin
      n_fail++; $display("FAIL spam_result: got sig=%h pat=%h, want sig=%h pat=%h",
                         big_sig, big_pat, good_sig, pat_q[BIG_CNT-1]);
    end
  endtask

  task automatic test_abort;
    logic [59:0] p;
    logic [25:0] exp_sig;
    p = BIG_SEED;
    exp_sig = '0;
    // Abort is sampled on the 10th edge after start; compaction stops one edge before.
    for (int i = 0; i < 9 - PIPE; i++) begin
      exp_sig = misr_m(exp_sig, resp_fn(p));
      p = lfsr_m(p);
    end
    big_start = 1'b1;
    @(posedge clk); #1;
    big_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    big_abort = 1'b1;
    big_start = 1'b1;
    @(posedge clk); #1;
    big_abort = 1'b0;
    big_start = 1'b0;
    n_checks++;
    if (big_busy !== 1'b0 || big_done !== 1'b0 || big_pat !== 60'h0) begin
      n_fail++; $display("FAIL abort_state: got busy=%b done=%b pat=%h, want 0 0 0",
                         big_busy, big_done, big_pat);
    end
    n_checks++;
    if (big_sig !== exp_sig) begin
      n_fail++; $display("FAIL abort_sig_hold: got %h, want %h", big_sig, exp_sig);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run;
    int seen;
    big_start = 1'b1;
    @(posedge clk); #1;
    big_start = 1'b0;
    repeat (500) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({big_pat, big_sig, big_busy, big_done, big_pass} !== '0) begin
      n_fail++; $display("FAIL reset_mid_run: got pat=%h sig=%h busy=%b done=%b pass=%b, want all 0",
                         big_pat, big_sig, big_busy, big_done, big_pass);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (big_done || big_busy || big_pat != 60'h0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_no_done: got %0d active cycles after release, want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b0;
    stuck = 1'b0;
    big_start = 1'b0; big_abort = 1'b0; big_golden = '0;
    sm_start = 1'b0;  sm_abort = 1'b0;  sm_golden = '0;
    z_start = 1'b0;   z_abort = 1'b0;   z_golden = '0;
    test_reset;
    test_zero_count;
    test_small;
    test_full_run;
    test_start_spam;
    test_abort;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/c880_bist.md
C880_BIST -- requirements
Module: c880_bist

Interface
REQ-001 Parameter PATTERN_CNT, default 16'd1023: number of patterns per run (16-bit).
REQ-002 Parameter SEED, default 60'h1: LFSR seed; a value of zero SHALL be replaced by 60'h1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  run request; sampled only in IDLE or DONE.
REQ-006 abort  input  1  terminate run; return to IDLE without done.
REQ-007 golden_sig  input  26  expected signature; compared only while done=1.
REQ-008 pattern_o  output  60  registered stimulus to c880 inputs N1..N268, in port-list order, bit 59 = N1.
REQ-009 response_i  input  26  c880 outputs N388..N880, in port-list order, bit 25 = N388.
REQ-010 busy  output  1  high in RUN/DRAIN.
REQ-011 done  output  1  high in DONE; held until next accepted start, abort or reset.
REQ-012 pass  output  1  done && (signature_o == golden_sig).
REQ-013 signature_o  output  26  MISR contents.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN (macro only), DONE.
REQ-015 Accepted start SHALL: load LFSR with SEED, clear MISR, clear the 16-bit pattern counter, go to RUN; the first RUN cycle shows pattern_o=SEED.
REQ-016 LFSR SHALL advance once per RUN cycle: next = {lfsr[58:0], lfsr[59]^lfsr[58]}.
REQ-017 MISR SHALL update once per compaction cycle: next = {sig[24:0],1'b0} ^ (sig[25] ? 26'h47 : 0) ^ resp.
REQ-018 Without C880_BIST_PIPE_EN, resp SHALL be response_i sampled in the same cycle as the corresponding pattern_o (single-cycle DUT path).
REQ-019 RUN SHALL last exactly PATTERN_CNT cycles; at the edge where counter==PATTERN_CNT-1, the last compaction occurs and the FSM goes to DONE (no macro) or DRAIN (macro).
REQ-020 If start is accepted at edge E, done SHALL be high after edge E+PATTERN_CNT (no macro) or E+PATTERN_CNT+1 (macro).
REQ-021 PATTERN_CNT=0 SHALL go from start directly to DONE in one cycle with signature_o=0.
REQ-022 start during RUN/DRAIN SHALL be ignored; start in DONE SHALL restart per REQ-015 and drop done on the same edge.
REQ-023 abort SHALL have priority over start and RUN progress: next state IDLE; signature_o SHALL hold its value; pattern_o SHALL go to 0.
REQ-024 pattern_o SHALL be 0 in IDLE, and SHALL hold the last pattern applied in DONE.

Reset
REQ-025 rst SHALL asynchronously force: state=IDLE, pattern_o=0, signature_o=0, counter=0, busy=0, done=0, pass=0.
REQ-026 rst asserted mid-run SHALL discard the run; no done pulse SHALL follow deassertion.

Configuration
REQ-027 Macro C880_BIST_PIPE_EN defined: response_i SHALL be registered one stage before the MISR, and the DRAIN state (one cycle) SHALL compact the final response.
REQ-028 Without C880_BIST_PIPE_EN: no response register and no DRAIN state; the signature is identical for the same DUT.

Structure
REQ-029 Package c880_bist_pkg SHALL hold: state enum, LFSR_W=60, MISR_W=26, MISR_POLY=26'h47, CNT_W=16.
REQ-030 One sub-module, c880_bist_misr (26-bit MISR with enable and clear), SHALL be used; LFSR, counter and FSM SHALL stay in the top level.

Verification
REQ-031 Reset mid-RUN (PATTERN_CNT=1023, cycle 500) -> all outputs 0 immediately; after release, IDLE, no done.
REQ-032 PATTERN_CNT=2, SEED=1, response_i=26'h1 -> pattern_o 60'h1 then 60'h2; signature_o=26'h3; done after edge E+2 (E+3 with macro); pass=1 with golden_sig=26'h3, 0 with 26'h2.
REQ-033 PATTERN_CNT=0, start -> done after one edge, signature_o=0, pass=1 with golden_sig=0.
REQ-034 start pulsed every cycle during RUN -> done at the same edge as single start; abort at cycle 10 -> IDLE, done=0, pattern_o=0.
REQ-035 Full run with c880 instance, PATTERN_CNT=1023 -> signature_o matches reference-model MISR with and without C880_BIST_PIPE_EN; a single stuck-at-0 injected on N880 -> pass=0.
